// File: rtl/signed_fixed_point_divider.sv
// Sequential signed divider: 2*WIDTH-bit dividend / WIDTH-bit divisor.
// Restoring shift-subtract on magnitudes; the quotient truncates toward zero and the remainder takes the dividend's sign.
module signed_fixed_point_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_hi,
  input  logic [WIDTH-1:0] dividend_lo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;
  localparam logic [WIDTH-1:0] Q_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_MIN    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH-1);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0]   r_dsr;
  logic [WIDTH-1:0]   r_dsr_mag;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_q;
  logic               r_q_neg;
  logic               r_r_neg;

  logic               w_dvd_neg;
  logic               w_dsr_neg;
  logic [2*WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0]   w_dsr_mag;
  logic               w_q_neg;
  logic               w_early_ovf;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_next;
  logic               w_late_ovf;
  logic [WIDTH-1:0]   w_q_signed;
  logic [WIDTH-1:0]   w_r_signed;

  assign w_dvd_neg   = r_dvd[2*WIDTH-1];
  assign w_dsr_neg   = r_dsr[WIDTH-1];
  assign w_dvd_mag   = w_dvd_neg ? -r_dvd : r_dvd;
  assign w_dsr_mag   = w_dsr_neg ? -r_dsr : r_dsr;
  assign w_q_neg     = w_dvd_neg ^ w_dsr_neg;
  // A high half >= divisor means the quotient cannot fit in WIDTH unsigned bits.
  assign w_early_ovf = w_dvd_mag[2*WIDTH-1:WIDTH] >= w_dsr_mag;

  assign w_shift    = {r_rem, r_lo[WIDTH-1]};
  assign w_ge       = w_shift >= {1'b0, r_dsr_mag};
  assign w_rem_next = w_ge ? WIDTH'(w_shift - {1'b0, r_dsr_mag}) : w_shift[WIDTH-1:0];

  // Magnitude 0x8000 is representable only when the result is negative.
  assign w_late_ovf = r_q_neg ? (r_q[WIDTH-1] & (|r_q[WIDTH-2:0])) : r_q[WIDTH-1];
  assign w_q_signed = r_q_neg ? -r_q : r_q;
  assign w_r_signed = r_r_neg ? -r_rem : r_rem;

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dsr       <= '0;
      r_dsr_mag   <= '0;
      r_rem       <= '0;
      r_lo        <= '0;
      r_q         <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd   <= {dividend_hi, dividend_lo};
            r_dsr   <= divisor;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_dsr_mag <= w_dsr_mag;
          r_rem     <= w_dvd_mag[2*WIDTH-1:WIDTH];
          r_lo      <= w_dvd_mag[WIDTH-1:0];
          r_q       <= '0;
          r_q_neg   <= w_q_neg;
          r_r_neg   <= w_dvd_neg;
          r_cnt     <= '0;
          if (r_dsr == '0) begin
            quotient    <= w_dvd_neg ? Q_MIN : Q_MAX;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            r_state     <= S_IDLE;
          end else if (w_early_ovf) begin
            quotient    <= w_q_neg ? Q_MIN : Q_MAX;
            remainder   <= '0;
            overflow    <= 1'b1;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_lo  <= {r_lo[WIDTH-2:0], 1'b0};
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          if (r_cnt == CNT_LAST) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (w_late_ovf) begin
            quotient  <= r_q_neg ? Q_MIN : Q_MAX;
            remainder <= '0;
            overflow  <= 1'b1;
          end else begin
            quotient  <= w_q_signed;
            remainder <= w_r_signed;
            overflow  <= 1'b0;
          end
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_fixed_point_divider.sv
// Self-checking bench for signed_fixed_point_divider: vector table through a scoreboard,
// then hand-written sequences for start-while-busy, back-to-back and mid-operation reset.
module tb_signed_fixed_point_divider;

  logic        clock = 1'b0;
  logic        aclr_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend_hi = '0;
  logic [15:0] dividend_lo = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic [15:0] dsr;
    logic [15:0] q;
    logic [15:0] r;
    logic        ovf;
    logic        dbz;
    logic        err;   // resolved in LOAD: short latency
  } vec_t;

  vec_t vecs[14];
  vec_t sb[$];

  signed_fixed_point_divider #(.WIDTH(16)) dut (
    .clock(clock), .aclr_n(aclr_n), .start(start),
    .dividend_hi(dividend_hi), .dividend_lo(dividend_lo), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one operation and returns the number of edges after the start edge until done is seen.
  task automatic run_op(input logic [15:0] hi, input logic [15:0] lo, input logic [15:0] dsr,
                        input bit b2b, output int lat, output bit tmo);
    if (!b2b) @(negedge clock);
    dividend_hi = hi;
    dividend_lo = lo;
    divisor     = dsr;
    start       = 1'b1;
    @(posedge clock);
    #1;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    tmo = 1'b0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (!done && lat < 40);
    if (!done) begin
      tmo = 1'b1;
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d edges, expected done", lat);
    end
  endtask

  task automatic check_result(input string tag, input int lat);
    vec_t e;
    e = sb.pop_front();
    chk({tag, "_quotient"},  {16'd0, quotient},  {16'd0, e.q});
    chk({tag, "_remainder"}, {16'd0, remainder}, {16'd0, e.r});
    chk({tag, "_overflow"},  {31'd0, overflow},  {31'd0, e.ovf});
    chk({tag, "_div0"},      {31'd0, div_by_zero}, {31'd0, e.dbz});
    if (e.err) begin
      checks++;
      if (lat > 2) begin
        errors++;
        $display("FAIL %s_latency: got %0d edges expected at most 2", tag, lat);
      end
    end else begin
      chk({tag, "_latency"}, lat, 32'd18);
    end
  endtask

  initial begin
    int lat;
    bit tmo;
    int dones;
    vecs[0]  = '{16'h0000, 16'h0006, 16'h0003, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'hE2B4, 16'h0019, 16'hFED4, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16'h0000, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'hFFFF, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'h0000, 16'h0005, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{16'h0001, 16'h0000, 16'h0001, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{16'h8000, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{16'hFFFF, 16'h0000, 16'h0002, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{16'h0000, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{16'hFFFF, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{16'h0000, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{16'h1234, 16'h5678, 16'h4000, 16'h48D1, 16'h1678, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{16'h0000, 16'h8000, 16'h8000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_quotient",  {16'd0, quotient},  32'd0);
    chk("rst_remainder", {16'd0, remainder}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_done",      {31'd0, done},      32'd0);
    chk("rst_overflow",  {31'd0, overflow},  32'd0);
    chk("rst_div0",      {31'd0, div_by_zero}, 32'd0);
    @(negedge clock);
    aclr_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      sb.push_back(vecs[i]);
      run_op(vecs[i].hi, vecs[i].lo, vecs[i].dsr, 1'b0, lat, tmo);
      check_result($sformatf("vec%0d", i), lat);
    end

    // Start pulsed mid-calculation must be ignored.
    sb.push_back(vecs[0]);
    fork
      run_op(16'h0000, 16'h0006, 16'h0003, 1'b0, lat, tmo);
      begin
        repeat (5) @(negedge clock);
        dividend_lo = 16'h0064;
        divisor     = 16'h0007;
        start       = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
    join
    check_result("busy_start", lat);
    repeat (3) @(posedge clock);
    #1;
    chk("held_quotient", {16'd0, quotient}, 32'd2);
    chk("done_pulse_len", {31'd0, done}, 32'd0);

    // Back-to-back: start asserted in the done cycle.
    sb.push_back(vecs[11]);
    run_op(vecs[11].hi, vecs[11].lo, vecs[11].dsr, 1'b0, lat, tmo);
    sb.push_back(vecs[3]);
    run_op(vecs[3].hi, vecs[3].lo, vecs[3].dsr, 1'b1, lat, tmo);
    void'(sb.pop_front());
    check_result("b2b", lat);

    // Reset in the middle of CALC.
    sb.push_back(vecs[0]);
    run_op(vecs[0].hi, vecs[0].lo, vecs[0].dsr, 1'b0, lat, tmo);
    check_result("pre_rst", lat);
    @(negedge clock);
    dividend_lo = 16'h0064;
    divisor     = 16'h0007;
    start       = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    aclr_n = 1'b0;
    #1;
    chk("midrst_busy",      {31'd0, busy},      32'd0);
    chk("midrst_quotient",  {16'd0, quotient},  32'd0);
    chk("midrst_remainder", {16'd0, remainder}, 32'd0);
    chk("midrst_done",      {31'd0, done},      32'd0);
    repeat (2) @(negedge clock);
    aclr_n = 1'b1;
    dones = 0;
    repeat (25) begin
      @(posedge clock);
      #1;
      if (done) dones++;
    end
    chk("midrst_no_done", dones, 32'd0);

    sb.push_back(vecs[1]);
    run_op(vecs[1].hi, vecs[1].lo, vecs[1].dsr, 1'b0, lat, tmo);
    check_result("post_rst", lat);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
